// File: rtl/uart_sim_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_sim_rx_ctrl
// Description : Oversample tick generator, rdy/rdy_clr handshake, byte FIFO
//               with valid/ready output, overflow flag and line-idle monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sim_rx_ctrl #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int IDLE_BITS  = 4
) (
    input  logic                          clk_50m,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          rx,
    output logic                          clken,
    input  logic                          rx_rdy,
    input  logic [7:0]                    rx_data,
    output logic                          rx_rdy_clr,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          line_idle
);

    localparam int DIV_RAW  = CLK_HZ / (BAUD * 16);
    localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int LW       = AW + 1;
    localparam int IDLE_MAX = IDLE_BITS * 16;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [LW-1:0]     FULL_LVL  = LW'(FIFO_DEPTH);
    localparam logic [IDLE_W-1:0] IDLE_FULL = IDLE_W'(IDLE_MAX);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_CLR  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    logic [DIV_W-1:0]  div_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    state_t            state;
    state_t            state_nxt;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              drop;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;

    // ------------------------------------------------------------------
    // Oversample tick: counter parks at 0 while disabled
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!en || (div_cnt == DIV_LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign clken = en && (div_cnt == DIV_LAST);

    // ------------------------------------------------------------------
    // Receiver handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        case (state)
            ST_WAIT: begin
                if (rx_rdy) begin
                    push_req  = 1'b1;
                    state_nxt = ST_CLR;
                end
            end
            ST_CLR: begin
                state_nxt = ST_ACK;
            end
            ST_ACK: begin
                // Receiver keeps rdy up until it sees rdy_clr; wait it out.
                if (!rx_rdy) begin
                    state_nxt = ST_WAIT;
                end
            end
            default: begin
                state_nxt = ST_WAIT;
            end
        endcase
    end

    assign rx_rdy_clr = (state == ST_CLR);

    // ------------------------------------------------------------------
    // Byte FIFO; a pop in the same cycle frees the slot for a full push
    // ------------------------------------------------------------------
    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;
    assign push_ok = push_req && ((count != FULL_LVL) || pop);
    assign drop    = push_req && !push_ok;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign m_data = mem[rd_ptr];
    assign level  = count;

    // Set has priority over clear so a drop is never silently lost.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Line-idle monitor, counted in oversample ticks
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!rx) begin
            idle_cnt <= '0;
        end else if (clken && (idle_cnt != IDLE_FULL)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign line_idle = rx && (idle_cnt == IDLE_FULL);

endmodule
`default_nettype wire
